// File: rtl/decode_prefix_parse.sv
// decode_prefix_parse
//   Decode front stage: strips up to MAX_PREF legacy prefixes (F3, 66, 2E, 36,
//   3E, 26, 64, 65) from a byte-aligned instruction window. It produces the
//   prefix flags, the segment one-hot, the prefix count and opcode bytes B1..B3.
//   Results are held in a 2-entry skid buffer: main entry M and skid entry K.
//   Both sides use a valid/ready handshake.
//
//   Ports
//     clk, clr            clock, asynchronous active-low reset
//     in_valid/in_ready   upstream handshake; in_ready = skid entry empty
//     in_bytes            window, lowest address byte in [7:0]
//     flush               synchronous kill of both entries
//     out_valid/out_ready downstream handshake
//     isREP/isSIZE/isSEG  prefix-group flags
//     segSEL              one-hot segment override (last override wins)
//     prefSize/pref_len   prefix count, one-hot and binary
//     B1/B2/B3            bytes at offsets pref_len, +1, +2
//     pref_err            repeated group, or a prefix at byte MAX_PREF
//
//   Optional feature: define DPP_PERF_CNT_EN to add perf_pref_cnt[15:0].
//   This is a saturating count of instructions with prefixes that load into M.
module decode_prefix_parse #(
  parameter int unsigned NBYTES   = 16,
  parameter int unsigned MAX_PREF = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [8*NBYTES-1:0] in_bytes,
  output logic                in_ready,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                isREP,
  output logic                isSIZE,
  output logic                isSEG,
  output logic [5:0]          segSEL,
  output logic [3:0]          prefSize,
  output logic [1:0]          pref_len,
  output logic [7:0]          B1,
  output logic [7:0]          B2,
  output logic [7:0]          B3,
  output logic                pref_err
`ifdef DPP_PERF_CNT_EN
  ,
  output logic [15:0]         perf_pref_cnt
`endif
);

  typedef struct packed {
    logic       rep;
    logic       size;
    logic       seg;
    logic [5:0] sel;
    logic [3:0] psz;
    logic [1:0] len;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic       err;
  } dec_t;

  localparam dec_t DEC_RST = '{rep: 1'b0, size: 1'b0, seg: 1'b0, sel: 6'd0,
                               psz: 4'b0001, len: 2'd0, b1: 8'd0, b2: 8'd0,
                               b3: 8'd0, err: 1'b0};

  function automatic logic is_pref(input logic [7:0] b);
    case (b)
      8'hF3, 8'h66, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65: is_pref = 1'b1;
      default:                                                is_pref = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] seg_onehot(input logic [7:0] b);
    case (b)
      8'h2E:   seg_onehot = 6'b000001;
      8'h36:   seg_onehot = 6'b000010;
      8'h3E:   seg_onehot = 6'b000100;
      8'h26:   seg_onehot = 6'b001000;
      8'h64:   seg_onehot = 6'b010000;
      8'h65:   seg_onehot = 6'b100000;
      default: seg_onehot = 6'b000000;
    endcase
  endfunction

  dec_t        w_dec;
  logic        w_scan;
  logic [7:0]  w_byte;
  int unsigned w_cnt;
  logic        w_acc;
  logic        w_unused_bytes;

  dec_t        r_m;
  dec_t        r_k;
  logic        r_m_v;
  logic        r_k_v;

  // Only the first MAX_PREF+3 bytes of the window can ever be observed.
  assign w_unused_bytes = ^in_bytes[8*NBYTES-1:8*(MAX_PREF+3)];

  // Prefix scan: stop at the first non-prefix byte.
  always_comb begin
    w_dec  = DEC_RST;
    w_scan = 1'b1;
    w_cnt  = 0;
    w_byte = 8'd0;
    for (int i = 0; i < int'(MAX_PREF); i++) begin
      w_byte = in_bytes[8*i +: 8];
      if (w_scan && is_pref(w_byte)) begin
        w_cnt = w_cnt + 1;
        if (w_byte == 8'hF3) begin
          if (w_dec.rep) w_dec.err = 1'b1;
          w_dec.rep = 1'b1;
        end else if (w_byte == 8'h66) begin
          if (w_dec.size) w_dec.err = 1'b1;
          w_dec.size = 1'b1;
        end else begin
          if (w_dec.seg) w_dec.err = 1'b1;
          w_dec.seg = 1'b1;
          w_dec.sel = seg_onehot(w_byte);
        end
      end else begin
        w_scan = 1'b0;
      end
    end
    // A prefix at byte MAX_PREF is flagged but still passed on as B1.
    if (w_scan && is_pref(in_bytes[8*MAX_PREF +: 8])) w_dec.err = 1'b1;
    w_dec.len = 2'(w_cnt);
    w_dec.psz = 4'(4'b0001 << w_cnt);
    w_dec.b1  = in_bytes[8*w_cnt +: 8];
    w_dec.b2  = in_bytes[8*(w_cnt+1) +: 8];
    w_dec.b3  = in_bytes[8*(w_cnt+2) +: 8];
  end

  assign w_acc = in_valid & in_ready;

  // Skid buffer. K drains into M before M can take new input.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_m_v <= 1'b0;
      r_k_v <= 1'b0;
      r_m   <= DEC_RST;
      r_k   <= DEC_RST;
    end else if (flush) begin
      r_m_v <= 1'b0;
      r_k_v <= 1'b0;
    end else if (r_m_v && out_ready && r_k_v) begin
      r_m   <= r_k;
      r_k_v <= 1'b0;
    end else if (w_acc && (!r_m_v || out_ready)) begin
      r_m   <= w_dec;
      r_m_v <= 1'b1;
    end else if (w_acc) begin
      r_k   <= w_dec;
      r_k_v <= 1'b1;
    end else if (out_ready) begin
      r_m_v <= 1'b0;
    end
  end

`ifdef DPP_PERF_CNT_EN
  logic        w_cnt_inc;
  logic [15:0] r_perf;

  // Count an instruction when it reaches M, whether from K or directly.
  always_comb begin
    w_cnt_inc = 1'b0;
    if (!flush) begin
      if (r_m_v && out_ready && r_k_v)           w_cnt_inc = (r_k.len != 2'd0);
      else if (w_acc && (!r_m_v || out_ready))   w_cnt_inc = (w_dec.len != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                                r_perf <= 16'd0;
    else if (w_cnt_inc && r_perf != 16'hFFFF) r_perf <= r_perf + 16'd1;
  end

  assign perf_pref_cnt = r_perf;
`endif

  assign in_ready  = ~r_k_v;
  assign out_valid = r_m_v;
  assign isREP     = r_m.rep;
  assign isSIZE    = r_m.size;
  assign isSEG     = r_m.seg;
  assign segSEL    = r_m.sel;
  assign prefSize  = r_m.psz;
  assign pref_len  = r_m.len;
  assign B1        = r_m.b1;
  assign B2        = r_m.b2;
  assign B3        = r_m.b3;
  assign pref_err  = r_m.err;

endmodule
